// File: rtl/pc_sequencer_if.sv
// Instruction-memory request/grant/return bus between pc_sequencer (master) and imem (slave).
interface pc_sequencer_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/pc_sequencer.sv
// Fetch-stage PC sequencer: FETCH/WAIT/OUT imem handshake with delay-slot redirects.
// Build macro PC_ALIGN_CHECK_EN: word-aligns redirect targets and pulses exc_adel_o on misalignment.
module pc_sequencer (
  input  logic           clk,
  input  logic           reset,
  input  logic           stall_i,
  input  logic           br_valid_i,
  input  logic [31:0]    br_target_i,
  pc_sequencer_if.master imem,
  output logic           if_valid_o,
  output logic [31:0]    if_instr_o,
  output logic [31:0]    if_pc_o,
  output logic           exc_adel_o
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    OUT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q;
  logic        pend_valid_q;
  logic [31:0] pend_target_q;
  logic        capture;
  logic        consume;
  logic        redirect;
  logic [31:0] raw_target;
  logic [31:0] redirect_pc;
  logic [31:0] next_pc;

  // NOTE: sequential state uses <= so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH;
    else       state_q <= state_d;
  end

  // NOTE: every signal written here gets a default first, so no path through the case can infer a latch.
  always_comb begin
    state_d         = state_q;
    imem.imem_req_o = 1'b0;
    capture         = 1'b0;
    consume         = 1'b0;
    case (state_q)
      FETCH: begin
        imem.imem_req_o = 1'b1;
        if (imem.imem_gnt_i) state_d = WAIT;
      end
      WAIT: begin
        if (imem.imem_rvalid_i) begin
          capture = 1'b1;
          state_d = OUT;
        end
      end
      OUT: begin
        if (!stall_i) begin
          consume = 1'b1;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // A live pulse beats the remembered one; with neither, fall through sequentially.
  assign redirect   = br_valid_i | pend_valid_q;
  assign raw_target = br_valid_i ? br_target_i : pend_target_q;

`ifdef PC_ALIGN_CHECK_EN
  logic adel_q;

  assign redirect_pc = {raw_target[31:2], 2'b00};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) adel_q <= 1'b0;
    else       adel_q <= consume & redirect & (raw_target[1:0] != 2'b00);
  end

  assign exc_adel_o = adel_q;
`else
  assign redirect_pc = raw_target;
  assign exc_adel_o  = 1'b0;
`endif

  assign next_pc          = redirect ? redirect_pc : pc_q + 32'd4;
  assign imem.imem_addr_o = pc_q;

  // pc only moves on consumption, which keeps the address stable across an ungranted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 32'h0;
      if_valid_o    <= 1'b0;
      if_instr_o    <= 32'h0;
      if_pc_o       <= 32'h0;
    end else begin
      if (capture) begin
        if_valid_o <= 1'b1;
        if_instr_o <= imem.imem_rdata_i;
        if_pc_o    <= pc_q;
      end
      if (consume) begin
        pc_q         <= next_pc;
        if_valid_o   <= 1'b0;
        pend_valid_q <= 1'b0;
      end else if (br_valid_i) begin
        pend_valid_q  <= 1'b1;
        pend_target_q <= br_target_i;
      end
    end
  end

`ifndef SYNTHESIS
  a_addr_stable: assert property (@(posedge clk) disable iff (reset)
    (imem.imem_req_o && !imem.imem_gnt_i) |=> $stable(imem.imem_addr_o));

  a_out_hold: assert property (@(posedge clk) disable iff (reset)
    (state_q == OUT && stall_i) |=> (if_valid_o && $stable(if_instr_o) && $stable(if_pc_o)));
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus randomized traffic against a reference model.
module tb_pc_sequencer;

  logic        clk;
  logic        reset;
  logic        stall_i;
  logic        br_valid_i;
  logic [31:0] br_target_i;
  logic        if_valid_o;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;
  logic        exc_adel_o;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .stall_i     (stall_i),
    .br_valid_i  (br_valid_i),
    .br_target_i (br_target_i),
    .imem        (bus),
    .if_valid_o  (if_valid_o),
    .if_instr_o  (if_instr_o),
    .if_pc_o     (if_pc_o),
    .exc_adel_o  (exc_adel_o)
  );

`ifdef PC_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Memory responder knobs and state.
  int          gnt_lat, rv_lat, gnt_cnt, rv_cnt;
  bit          in_req, mem_busy, junk_en, late_rvalid, override_en;
  logic [31:0] mem_addr_lat, override_data;
  bit          last_req_ng;
  logic [31:0] last_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic respond();
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    if (bus.imem_req_o) begin
      if (!in_req) begin
        in_req  = 1'b1;
        gnt_cnt = gnt_lat;
      end
      if (gnt_cnt == 0) begin
        bus.imem_gnt_i = 1'b1;
        in_req         = 1'b0;
        mem_busy       = 1'b1;
        mem_addr_lat   = bus.imem_addr_o;
        rv_cnt         = rv_lat;
      end else begin
        gnt_cnt--;
      end
      if (late_rvalid || (junk_en && $urandom_range(0, 3) == 0)) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = 32'hBAD0_0000 | 32'($urandom_range(0, 255));
      end
      late_rvalid = 1'b0;
    end else if (mem_busy) begin
      if (rv_cnt == 0) begin
        bus.imem_rvalid_i = 1'b1;
        bus.imem_rdata_i  = override_en ? override_data : mem_word(mem_addr_lat);
        mem_busy          = 1'b0;
      end else begin
        rv_cnt--;
      end
    end
  endtask

  task automatic tick();
    respond();
    last_req_ng = bus.imem_req_o && !bus.imem_gnt_i;
    last_addr   = bus.imem_addr_o;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clear_responder();
    in_req      = 1'b0;
    mem_busy    = 1'b0;
    late_rvalid = 1'b0;
    last_req_ng = 1'b0;
  endtask

  task automatic apply_reset();
    reset       = 1'b1;
    stall_i     = 1'b0;
    br_valid_i  = 1'b0;
    br_target_i = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_responder();
  endtask

  task automatic wait_valid(output bit ok);
    int n;
    n = 0;
    while (!if_valid_o && n < 40) begin
      tick();
      n++;
    end
    ok = if_valid_o;
  endtask

  task automatic wait_req(output bit ok);
    int n;
    n = 0;
    while (!bus.imem_req_o && n < 40) begin
      tick();
      n++;
    end
    ok = bus.imem_req_o;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_if_valid: got %0b want 0", if_valid_o); end
    n_cmp++; if (if_instr_o !== 32'h0) begin n_bad++; $display("FAIL reset_if_instr: got %08h want 00000000", if_instr_o); end
    n_cmp++; if (if_pc_o !== 32'h0) begin n_bad++; $display("FAIL reset_if_pc: got %08h want 00000000", if_pc_o); end
    n_cmp++; if (exc_adel_o !== 1'b0) begin n_bad++; $display("FAIL reset_exc_adel: got %0b want 0", exc_adel_o); end
    n_cmp++; if (bus.imem_addr_o !== 32'h3000) begin n_bad++; $display("FAIL reset_pc: got %08h want 00003000", bus.imem_addr_o); end
    reset = 1'b0;
    clear_responder();
    n_cmp++; if (bus.imem_req_o !== 1'b1) begin n_bad++; $display("FAIL reset_release_req: got %0b want 1", bus.imem_req_o); end
  endtask

  task automatic test_first_fetch();
    gnt_lat = 0;
    rv_lat  = 0;
    override_en   = 1'b1;
    override_data = 32'h2408_0001;
    tick();
    n_cmp++; if (if_valid_o !== 1'b0) begin n_bad++; $display("FAIL first_valid_early: got %0b want 0 at cycle 2", if_valid_o); end
    tick();
    override_en = 1'b0;
    n_cmp++; if (if_valid_o !== 1'b1) begin n_bad++; $display("FAIL first_valid_cycle3: got %0b want 1", if_valid_o); end
    n_cmp++; if (if_pc_o !== 32'h3000) begin n_bad++; $display("FAIL first_pc: got %08h want 00003000", if_pc_o); end
    n_cmp++; if (if_instr_o !== 32'h2408_0001) begin n_bad++; $display("FAIL first_instr: got %08h want 24080001", if_instr_o); end
    tick();
    n_cmp++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h3004) begin
      n_bad++; $display("FAIL first_next_addr: got req=%0b addr=%08h want req=1 addr=00003004", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_stall();
    bit          ok;
    logic [31:0] h_instr, h_pc;
    wait_valid(ok);
    n_cmp++; if (!ok || if_pc_o !== 32'h3004) begin n_bad++; $display("FAIL stall_arrive: got valid=%0b pc=%08h want 1/00003004", if_valid_o, if_pc_o); end
    h_instr = if_instr_o;
    h_pc    = if_pc_o;
    stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_cmp++; if (if_valid_o !== 1'b1 || if_instr_o !== h_instr || if_pc_o !== h_pc || bus.imem_req_o !== 1'b0) begin
        n_bad++; $display("FAIL stall_hold[%0d]: got v=%0b instr=%08h pc=%08h req=%0b want 1/%08h/%08h/0",
                          i, if_valid_o, if_instr_o, if_pc_o, bus.imem_req_o, h_instr, h_pc);
      end
    end
    stall_i = 1'b0;
    tick();
    n_cmp++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h3008) begin
      n_bad++; $display("FAIL stall_release_addr: got req=%0b addr=%08h want 1/00003008", bus.imem_req_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_delay_slot();
    bit ok;
    rv_lat = 1;
    tick();
    br_valid_i  = 1'b1;
    br_target_i = 32'h3100;
    tick();
    br_valid_i = 1'b0;
    wait_valid(ok);
    n_cmp++; if (!ok || if_pc_o !== 32'h3008 || if_instr_o !== mem_word(32'h3008)) begin
      n_bad++; $display("FAIL delay_slot_deliver: got v=%0b pc=%08h instr=%08h want 1/00003008/%08h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h3008));
    end
    tick();
    n_cmp++; if (bus.imem_addr_o !== 32'h3100) begin n_bad++; $display("FAIL delay_slot_target: got %08h want 00003100", bus.imem_addr_o); end
  endtask

  task automatic test_pending();
    bit ok;
    stall_i     = 1'b1;
    br_valid_i  = 1'b1;
    br_target_i = 32'h3100;
    tick();
    br_valid_i = 1'b0;
    tick();
    br_valid_i  = 1'b1;
    br_target_i = 32'h3200;
    tick();
    br_valid_i = 1'b0;
    wait_valid(ok);
    n_cmp++; if (!ok || if_pc_o !== 32'h3100) begin n_bad++; $display("FAIL pend_deliver: got v=%0b pc=%08h want 1/00003100", if_valid_o, if_pc_o); end
    stall_i = 1'b0;
    tick();
    n_cmp++; if (bus.imem_addr_o !== 32'h3200) begin n_bad++; $display("FAIL pend_overwrite: got %08h want 00003200", bus.imem_addr_o); end
    stall_i     = 1'b1;
    br_valid_i  = 1'b1;
    br_target_i = 32'h3300;
    tick();
    br_valid_i = 1'b0;
    wait_valid(ok);
    n_cmp++; if (!ok || if_pc_o !== 32'h3200 || if_instr_o !== mem_word(32'h3200)) begin
      n_bad++; $display("FAIL pend_deliver2: got v=%0b pc=%08h instr=%08h want 1/00003200/%08h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h3200));
    end
    stall_i     = 1'b0;
    br_valid_i  = 1'b1;
    br_target_i = 32'h3400;
    tick();
    br_valid_i = 1'b0;
    n_cmp++; if (bus.imem_addr_o !== 32'h3400) begin n_bad++; $display("FAIL pend_coincident: got %08h want 00003400", bus.imem_addr_o); end
    wait_valid(ok);
    tick();
    n_cmp++; if (!ok || bus.imem_addr_o !== 32'h3404) begin n_bad++; $display("FAIL pend_cleared: got %08h want 00003404", bus.imem_addr_o); end
  endtask

  task automatic test_align();
    bit          ok;
    logic [31:0] want_addr;
    want_addr = ALIGN ? 32'h3100 : 32'h3102;
    wait_valid(ok);
    n_cmp++; if (!ok || exc_adel_o !== 1'b0) begin n_bad++; $display("FAIL align_idle: got v=%0b exc=%0b want 1/0", if_valid_o, exc_adel_o); end
    br_valid_i  = 1'b1;
    br_target_i = 32'h3102;
    tick();
    br_valid_i = 1'b0;
    n_cmp++; if (bus.imem_addr_o !== want_addr) begin n_bad++; $display("FAIL align_addr: got %08h want %08h", bus.imem_addr_o, want_addr); end
    n_cmp++; if (exc_adel_o !== ALIGN) begin n_bad++; $display("FAIL align_exc_pulse: got %0b want %0b", exc_adel_o, ALIGN); end
    stall_i = 1'b1;
    tick();
    n_cmp++; if (exc_adel_o !== 1'b0) begin n_bad++; $display("FAIL align_exc_end: got %0b want 0", exc_adel_o); end
    stall_i = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    wait_req(ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL rst_wait_setup: got req=%0b want 1", bus.imem_req_o); end
    gnt_lat = 0;
    rv_lat  = 3;
    tick();
    n_cmp++; if (bus.imem_req_o !== 1'b0) begin n_bad++; $display("FAIL rst_wait_in_wait: got req=%0b want 0", bus.imem_req_o); end
    tick();
    reset = 1'b1;
    #1;
    n_cmp++; if (if_valid_o !== 1'b0 || if_pc_o !== 32'h0 || if_instr_o !== 32'h0 || bus.imem_addr_o !== 32'h3000) begin
      n_bad++; $display("FAIL rst_wait_async: got v=%0b pc=%08h instr=%08h addr=%08h want 0/0/0/00003000", if_valid_o, if_pc_o, if_instr_o, bus.imem_addr_o);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_responder();
    gnt_lat     = 1;
    rv_lat      = 0;
    late_rvalid = 1'b1;
    tick();
    n_cmp++; if (if_valid_o !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h3000) begin
      n_bad++; $display("FAIL rst_wait_discard: got v=%0b req=%0b addr=%08h want 0/1/00003000", if_valid_o, bus.imem_req_o, bus.imem_addr_o);
    end
    wait_valid(ok);
    n_cmp++; if (!ok || if_pc_o !== 32'h3000 || if_instr_o !== mem_word(32'h3000)) begin
      n_bad++; $display("FAIL rst_wait_refetch: got v=%0b pc=%08h instr=%08h want 1/00003000/%08h", if_valid_o, if_pc_o, if_instr_o, mem_word(32'h3000));
    end
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, pend_t, tgt, nxt, h_instr, h_pc;
    bit          pend_v, fresh, was_valid, exp_adel, redir;
    int          start_cyc, lat_exp, wait_cnt;
    apply_reset();
    junk_en   = 1'b1;
    gnt_lat   = $urandom_range(0, 3);
    rv_lat    = $urandom_range(0, 3);
    lat_exp   = 2 + gnt_lat + rv_lat;
    start_cyc = cyc;
    exp_pc    = 32'h3000;
    pend_v    = 1'b0;
    pend_t    = 32'h0;
    fresh     = 1'b1;
    was_valid = 1'b0;
    exp_adel  = 1'b0;
    wait_cnt  = 0;
    h_instr   = 32'h0;
    h_pc      = 32'h0;
    for (int i = 0; i < 3000; i++) begin
      n_cmp++; if (exc_adel_o !== exp_adel) begin n_bad++; $display("FAIL rnd_exc[%0d]: got %0b want %0b", i, exc_adel_o, exp_adel); end
      if (fresh) begin
        n_cmp++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== exp_pc) begin
          n_bad++; $display("FAIL rnd_fetch_addr[%0d]: got req=%0b addr=%08h want 1/%08h", i, bus.imem_req_o, bus.imem_addr_o, exp_pc);
        end
        fresh = 1'b0;
      end
      if (last_req_ng) begin
        n_cmp++; if (bus.imem_addr_o !== last_addr) begin n_bad++; $display("FAIL rnd_addr_stable[%0d]: got %08h want %08h", i, bus.imem_addr_o, last_addr); end
      end
      if (if_valid_o && !was_valid) begin
        n_cmp++; if (if_pc_o !== exp_pc || if_instr_o !== mem_word(exp_pc)) begin
          n_bad++; $display("FAIL rnd_deliver[%0d]: got pc=%08h instr=%08h want %08h/%08h", i, if_pc_o, if_instr_o, exp_pc, mem_word(exp_pc));
        end
        n_cmp++; if (cyc - start_cyc != lat_exp) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, cyc - start_cyc, lat_exp); end
        h_instr  = if_instr_o;
        h_pc     = if_pc_o;
        wait_cnt = 0;
      end else if (if_valid_o) begin
        n_cmp++; if (if_instr_o !== h_instr || if_pc_o !== h_pc || bus.imem_req_o !== 1'b0) begin
          n_bad++; $display("FAIL rnd_hold[%0d]: got instr=%08h pc=%08h req=%0b want %08h/%08h/0", i, if_instr_o, if_pc_o, bus.imem_req_o, h_instr, h_pc);
        end
      end else begin
        wait_cnt++;
        if (wait_cnt > 20) begin
          n_cmp++; n_bad++;
          $display("FAIL rnd_timeout[%0d]: got no if_valid_o within 20 cycles want delivery of %08h", i, exp_pc);
          break;
        end
      end
      was_valid = if_valid_o;

      stall_i    = ($urandom_range(0, 2) == 0);
      br_valid_i = ($urandom_range(0, 5) == 0);
      tgt        = 32'h3000 + ($urandom_range(0, 1023) << 2);
      if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      br_target_i = tgt;
      exp_adel    = 1'b0;
      if (if_valid_o && !stall_i) begin
        redir = br_valid_i || pend_v;
        nxt   = br_valid_i ? tgt : (pend_v ? pend_t : exp_pc + 32'd4);
        if (ALIGN && redir && nxt[1:0] != 2'b00) begin
          nxt[1:0] = 2'b00;
          exp_adel = 1'b1;
        end
        exp_pc    = nxt;
        pend_v    = 1'b0;
        fresh     = 1'b1;
        was_valid = 1'b0;
        gnt_lat   = $urandom_range(0, 3);
        rv_lat    = $urandom_range(0, 3);
        lat_exp   = 2 + gnt_lat + rv_lat;
        start_cyc = cyc + 1;
      end else if (br_valid_i) begin
        pend_v = 1'b1;
        pend_t = tgt;
      end
      tick();
      br_valid_i = 1'b0;
    end
    junk_en = 1'b0;
    stall_i = 1'b0;
  endtask

  initial begin
    reset             = 1'b1;
    stall_i           = 1'b0;
    br_valid_i        = 1'b0;
    br_target_i       = 32'h0;
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    gnt_lat           = 0;
    rv_lat            = 0;
    gnt_cnt           = 0;
    rv_cnt            = 0;
    junk_en           = 1'b0;
    override_en       = 1'b0;
    override_data     = 32'h0;
    mem_addr_lat      = 32'h0;
    last_addr         = 32'h0;
    clear_responder();

    test_reset();
    test_first_fetch();
    test_stall();
    test_delay_slot();
    test_pending();
    test_align();
    test_reset_in_wait();
    test_random();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
